// File: rtl/cache_mon_pkg.sv
// rtl/cache_mon_pkg.sv - shared types, constants and counter helper for cache_trace_monitor
// Optional feature macro: CACHE_MON_SAT_EN (saturating statistics counters)
package cache_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

  localparam logic [15:0] DEFAULT_WDATA_TAG = 16'h5678;

  // Statistic slots, one mon_counter each
  localparam int CNT_CLK   = 0;
  localparam int CNT_REQ   = 1;
  localparam int CNT_HIT   = 2;
  localparam int CNT_MISS  = 3;
  localparam int CNT_WRITE = 4;
  localparam int CNT_STALL = 5;
  localparam int NUM_CNT   = 6;

`ifdef CACHE_MON_SAT_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  // An increment is taken unless the counter is pinned at its maximum in saturating mode
  function automatic logic cnt_step_ok(input logic inc, input logic at_max);
    return inc && !(SAT_MODE && at_max);
  endfunction

endpackage

// File: rtl/mon_counter.sv
// rtl/mon_counter.sv - one statistics counter with clear/increment, wrap or saturate
// Optional feature macro: CACHE_MON_SAT_EN (adds sat_hit output, counter saturates)
module mon_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
`ifdef CACHE_MON_SAT_EN
  ,
  output logic             sat_hit
`endif
);
  import cache_mon_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  // Next count: clear wins, otherwise step unless held at the limit
  always_comb begin
    at_max = &cnt_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_step_ok(inc, at_max)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

`ifdef CACHE_MON_SAT_EN
  // An increment that was swallowed at the limit marks a saturation event
  assign sat_hit = inc && at_max && !clr;
`endif

endmodule

// File: rtl/cache_trace_monitor.sv
// rtl/cache_trace_monitor.sv - trace walker and cache statistics monitor with start/done run FSM
// Optional feature macro: CACHE_MON_SAT_EN (saturating counters plus sticky sat_flag output)
module cache_trace_monitor
  import cache_mon_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter int          IDX_W     = 4,
  parameter int          ADDR_W    = 32,
  parameter logic [15:0] WDATA_TAG = DEFAULT_WDATA_TAG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  trace_idx,
  input  logic              trace_valid,
  input  logic              trace_write,
  input  logic [ADDR_W-1:0] trace_addr,
  output logic              cache_req,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [31:0]       cache_wdata,
  input  logic              cache_stall,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  clk_count,
  output logic [CNT_W-1:0]  req_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  write_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  max_lat
`ifdef CACHE_MON_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  mon_state_e       state_q, state_d;
  logic [IDX_W-1:0] trace_idx_q, trace_idx_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] max_lat_q, max_lat_d;
  logic [7:0]       issue_clk_q, issue_clk_d;

  logic             run, start_go, accept, stalled, lat_zero, idx_last;
  logic [7:0]       issue_lo;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_v [NUM_CNT];

  // Request handshake and per-statistic increment strobes
  always_comb begin
    run       = (state_q == ST_RUN);
    start_go  = start && !run;
    cache_req = run && trace_valid;
    accept    = cache_req && !cache_stall;
    stalled   = cache_req && cache_stall;
    lat_zero  = (lat_q == '0);
    idx_last  = (trace_idx_q == '1);
    cnt_inc            = '0;
    cnt_inc[CNT_CLK]   = run;
    cnt_inc[CNT_REQ]   = accept;
    cnt_inc[CNT_HIT]   = accept && lat_zero;
    cnt_inc[CNT_MISS]  = accept && !lat_zero;
    cnt_inc[CNT_WRITE] = accept && trace_write;
    cnt_inc[CNT_STALL] = stalled;
  end

  // Run FSM next state: a missing entry or the last index accepted ends the run
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (!trace_valid || (accept && idx_last)) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Index, latency, worst latency and the issue-cycle snapshot that keeps wdata stable
  always_comb begin
    trace_idx_d = trace_idx_q;
    lat_d       = lat_q;
    max_lat_d   = max_lat_q;
    issue_clk_d = issue_clk_q;
    if (start_go) begin
      trace_idx_d = '0;
      lat_d       = '0;
      max_lat_d   = '0;
    end else if (accept) begin
      trace_idx_d = trace_idx_q + IDX_W'(1);
      lat_d       = '0;
      if (lat_q > max_lat_q) max_lat_d = lat_q;
    end else if (stalled) begin
      if (lat_zero) issue_clk_d = 8'(cnt_v[CNT_CLK]);
      if (lat_q != '1) lat_d = lat_q + CNT_W'(1);
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trace_idx_q <= '0;
      lat_q       <= '0;
      max_lat_q   <= '0;
      issue_clk_q <= '0;
    end else begin
      state_q     <= state_d;
      trace_idx_q <= trace_idx_d;
      lat_q       <= lat_d;
      max_lat_q   <= max_lat_d;
      issue_clk_q <= issue_clk_d;
    end
  end

`ifdef CACHE_MON_SAT_EN
  logic [NUM_CNT-1:0] sat_hit;
  logic               sat_flag_q, sat_flag_d;

  // Sticky saturation flag, cleared by a new run
  always_comb begin
    sat_flag_d = sat_flag_q | (|sat_hit);
    if (start_go) sat_flag_d = 1'b0;
  end

  // Saturation flag register
  always_ff @(posedge clk) begin
    if (rst) sat_flag_q <= 1'b0;
    else     sat_flag_q <= sat_flag_d;
  end

  assign sat_flag = sat_flag_q;
`endif

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    mon_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_go),
      .inc     (cnt_inc[g]),
      .cnt     (cnt_v[g])
`ifdef CACHE_MON_SAT_EN
      ,
      .sat_hit (sat_hit[g])
`endif
    );
  end

  assign issue_lo    = lat_zero ? 8'(cnt_v[CNT_CLK]) : issue_clk_q;
  assign cache_we    = trace_write;
  assign cache_addr  = trace_addr;
  assign cache_wdata = {WDATA_TAG, issue_lo, 8'(cnt_v[CNT_REQ])};
  assign trace_idx   = trace_idx_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign clk_count   = cnt_v[CNT_CLK];
  assign req_count   = cnt_v[CNT_REQ];
  assign hit_count   = cnt_v[CNT_HIT];
  assign miss_count  = cnt_v[CNT_MISS];
  assign write_count = cnt_v[CNT_WRITE];
  assign stall_count = cnt_v[CNT_STALL];
  assign max_lat     = max_lat_q;

endmodule

// File: tb/tb_cache_trace_monitor.sv
// tb/tb_cache_trace_monitor.sv - directed self-checking bench for cache_trace_monitor
// Optional feature macro: CACHE_MON_SAT_EN (checks saturation instead of wrap)
module tb_cache_trace_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cache_stall = 1'b0;
  logic [3:0]  trace_idx;
  logic        trace_valid, trace_write;
  logic [31:0] trace_addr;
  logic        cache_req, cache_we;
  logic [31:0] cache_addr, cache_wdata;
  logic        busy, done;
  logic [15:0] clk_count, req_count, hit_count, miss_count, write_count, stall_count, max_lat;
  logic        tv_mem [16];
  logic        tw_mem [16];

  logic        s_start = 1'b0;
  logic [4:0]  s_idx;
  logic        s_valid;
  logic        s_req, s_we, s_busy, s_done;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_clk, s_reqc, s_hit, s_miss, s_wr, s_stl, s_maxl;
`ifdef CACHE_MON_SAT_EN
  logic        sat_flag, s_sat;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  assign trace_valid = tv_mem[trace_idx];
  assign trace_write = tw_mem[trace_idx];
  assign trace_addr  = 32'h1000 + 32'(trace_idx) * 4;
  assign s_valid     = (s_idx < 5'd20);

  cache_trace_monitor dut (
    .clk(clk), .rst(rst), .start(start), .trace_idx(trace_idx),
    .trace_valid(trace_valid), .trace_write(trace_write), .trace_addr(trace_addr),
    .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_stall(cache_stall), .busy(busy), .done(done),
    .clk_count(clk_count), .req_count(req_count), .hit_count(hit_count),
    .miss_count(miss_count), .write_count(write_count), .stall_count(stall_count),
    .max_lat(max_lat)
`ifdef CACHE_MON_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  cache_trace_monitor #(.CNT_W(4), .IDX_W(5)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .trace_idx(s_idx),
    .trace_valid(s_valid), .trace_write(1'b0), .trace_addr({27'd0, s_idx}),
    .cache_req(s_req), .cache_we(s_we), .cache_addr(s_addr),
    .cache_wdata(s_wdata), .cache_stall(1'b0), .busy(s_busy), .done(s_done),
    .clk_count(s_clk), .req_count(s_reqc), .hit_count(s_hit),
    .miss_count(s_miss), .write_count(s_wr), .stall_count(s_stl),
    .max_lat(s_maxl)
`ifdef CACHE_MON_SAT_EN
    , .sat_flag(s_sat)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tv_mem[i] = 1'b1;
      tw_mem[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {31'd0, cache_req}, 32'd0);
    check("rst_idx", {28'd0, trace_idx}, 32'd0);
    check("rst_reqcnt", {16'd0, req_count}, 32'd0);
    check("rst_clkcnt", {16'd0, clk_count}, 32'd0);
    rst = 1'b0;

    // Straight run: 16 hits, no stalls
    do_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1", cyc);
    check("t1_cycles", cyc, 32'd16);
    check("t1_req", {16'd0, req_count}, 32'd16);
    check("t1_hit", {16'd0, hit_count}, 32'd16);
    check("t1_miss", {16'd0, miss_count}, 32'd0);
    check("t1_stall", {16'd0, stall_count}, 32'd0);
    check("t1_clk", {16'd0, clk_count}, 32'd16);
    check("t1_maxlat", {16'd0, max_lat}, 32'd0);
    check("t1_idx", {28'd0, trace_idx}, 32'd0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // Entry 3 stalls for 4 cycles
    do_start();
    repeat (3) @(negedge clk);
    cache_stall = 1'b1;
    check("t2_idx3", {28'd0, trace_idx}, 32'd3);
    check("t2_wdata_0", cache_wdata, 32'h5678_0303);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("t2_req_stl", {31'd0, cache_req}, 32'd1);
      check("t2_addr_stl", cache_addr, 32'h0000_100C);
      check("t2_wdata_stl", cache_wdata, 32'h5678_0303);
    end
    @(negedge clk) cache_stall = 1'b0;
    wait_done("t2", cyc);
    check("t2_req", {16'd0, req_count}, 32'd16);
    check("t2_hit", {16'd0, hit_count}, 32'd15);
    check("t2_miss", {16'd0, miss_count}, 32'd1);
    check("t2_stall", {16'd0, stall_count}, 32'd4);
    check("t2_maxlat", {16'd0, max_lat}, 32'd4);
    check("t2_clk", {16'd0, clk_count}, 32'd20);

    // Hole at index 5 ends the run early; counters hold until restarted
    tv_mem[5] = 1'b0;
    do_start();
    wait_done("t3", cyc);
    check("t3_req", {16'd0, req_count}, 32'd5);
    check("t3_clk", {16'd0, clk_count}, 32'd6);
    repeat (3) @(negedge clk);
    check("t3_hold_req", {16'd0, req_count}, 32'd5);
    check("t3_hold_done", {31'd0, done}, 32'd1);
    tv_mem[5] = 1'b1;
    tw_mem[1] = 1'b1;
    tw_mem[2] = 1'b1;
    do_start();
    check("t3_clr_req", {16'd0, req_count}, 32'd0);
    check("t3_clr_clk", {16'd0, clk_count}, 32'd0);
    check("t3_clr_maxlat", {16'd0, max_lat}, 32'd0);

    // Writes at entries 1 and 2; a start mid-run must be ignored
    @(negedge clk);
    check("t4_we", {31'd0, cache_we}, 32'd1);
    check("t4_addr", cache_addr, 32'h0000_1004);
    check("t4_wdata", cache_wdata, 32'h5678_0101);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("t4", cyc);
    check("t4_write", {16'd0, write_count}, 32'd2);
    check("t4_req", {16'd0, req_count}, 32'd16);
    check("t4_clk", {16'd0, clk_count}, 32'd16);
`ifdef CACHE_MON_SAT_EN
    check("t4_sat", {31'd0, sat_flag}, 32'd0);
`endif

    // Narrow counters: 20 requests through a 4-bit counter
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    cyc = 0;
    while (cyc < 200 && !s_done) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_done", {31'd0, s_done}, 32'd1);
`ifdef CACHE_MON_SAT_EN
    check("t6_req", {28'd0, s_reqc}, 32'd15);
    check("t6_clk", {28'd0, s_clk}, 32'd15);
    check("t6_sat", {31'd0, s_sat}, 32'd1);
`else
    check("t6_req", {28'd0, s_reqc}, 32'd4);
    check("t6_clk", {28'd0, s_clk}, 32'd5);
    check("t6_hit", {28'd0, s_hit}, 32'd4);
`endif

    // Reset during a stalled request
    do_start();
    cache_stall = 1'b1;
    @(negedge clk);
    check("t5_req_stl", {31'd0, cache_req}, 32'd1);
    check("t5_stall_cnt", {16'd0, stall_count}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_req", {31'd0, cache_req}, 32'd0);
    check("t5_stall", {16'd0, stall_count}, 32'd0);
    check("t5_clk", {16'd0, clk_count}, 32'd0);
    check("t5_idx", {28'd0, trace_idx}, 32'd0);
    rst = 1'b0;
    cache_stall = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_trace_monitor.md
Name: cache_trace_monitor

Overview:
- Parametrised successor to the cache-bench harness logic.
- Walks a trace source by index and issues each entry to the cache controller with a req/stall handshake.
- Collects cycle, request, hit, miss, write, stall and worst-case-latency statistics under a start/done run FSM.
- Sits between the trace ROM (inst) and cmu in the cache test top; the top instantiates it in place of hand-written counters.

Parameters:
- CNT_W, 16: width of every statistics counter.
- IDX_W, 4: trace index width; trace depth is 2^IDX_W entries.
- ADDR_W, 32: cache address width.
- WDATA_TAG, 16'h5678: upper half of generated write data.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle run request; honoured in IDLE/DONE only.
- trace_idx  out  IDX_W  index presented to the trace source.
- trace_valid  in  1  entry at trace_idx is valid (combinational read of trace_idx).
- trace_write  in  1  entry is a write.
- trace_addr  in  ADDR_W  entry address.
- cache_req  out  1  request to the cache.
- cache_we  out  1  write enable, equals trace_write.
- cache_addr  out  ADDR_W  equals trace_addr.
- cache_wdata  out  32  generated write data.
- cache_stall  in  1  cache not ready; request held while high.
- busy  out  1  FSM in RUN.
- done  out  1  FSM in DONE.
- clk_count, req_count, hit_count, miss_count, write_count, stall_count, max_lat  out  CNT_W each  statistics.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE, trace_idx=0, all counters=0, busy=0, done=0, cache_req=0.
- IDLE/DONE + start: clear all counters, trace_idx=0, lat=0; next state RUN. Counters hold their values in IDLE/DONE otherwise.
- RUN, request drive: cache_req = trace_valid, combinational. cache_we and cache_addr pass through. Request fields stay stable while cache_stall=1 because trace_idx does not advance.
- Acceptance: cycle with cache_req && !cache_stall. On acceptance:
  - req_count+1, and write_count+1 if trace_write.
  - hit_count+1 if internal lat==0, else miss_count+1.
  - max_lat = max(max_lat, lat). lat then clears to 0.
  - trace_idx+1.
- Stalled request cycle (cache_req && cache_stall): lat+1, stall_count+1.
- clk_count: +1 every cycle in RUN, including the terminating cycle.
- RUN -> DONE when either:
  - trace_valid=0 (no request that cycle); or
  - an acceptance occurs at trace_idx = 2^IDX_W-1 (no wrap into a second pass; trace_idx wraps to 0).
- cache_wdata = {WDATA_TAG, issue_clk[7:0], req_count[7:0]}. issue_clk is live clk_count when lat==0, else a copy captured in the request's first cycle, so wdata is stable across stalls.
- start during RUN is ignored.
- rst mid-request: cache_req drops next cycle; all state returns to reset values.
- Counter overflow wraps modulo 2^CNT_W by default (see optional feature). lat has CNT_W bits and stops incrementing at its maximum.
- hit_count + miss_count == req_count always (absent saturation).

Optional Feature:
- Macro: CACHE_MON_SAT_EN.
- Defined: every statistics counter saturates at 2^CNT_W-1, and a sticky sat_flag output (1 bit, cleared by rst/start) is added, set when any counter saturates.
- Undefined: counters wrap and no sat_flag port exists.

Decomposition:
- Package cache_mon_pkg: FSM state enum (IDLE, RUN, DONE), default WDATA_TAG, counter-update helper function (wrap/saturate selected by macro).
- One sub-module: mon_counter (CNT_W wide, clr/inc inputs, saturate mode), instantiated per statistic.

Test Plan:
- 16 valid reads, cache_stall always 0, start at cycle 2 -> done after 16 cycles; req=16, hit=16, miss=0, stall_count=0, clk_count=16, max_lat=0, trace_idx=0.
- Entry 3 stalls 4 cycles, others 0 -> req=16, hit=15, miss=1, stall_count=4, max_lat=4, clk_count=20. cache_addr/cache_wdata constant during the 4 stall cycles.
- trace_valid=0 at index 5 -> DONE after 5 acceptances; req=5. Counters hold until next start, then clear to 0.
- Entries 1 and 2 are writes, no stalls -> write_count=2. cache_wdata at entry 1 = 32'h5678_0101.
- rst asserted during a stalled request in RUN -> next cycle state IDLE, cache_req=0, all counters 0.
- CNT_W=4, 20 stall-free requests -> req_count=4 (wrap). With CACHE_MON_SAT_EN: req_count=15, sat_flag=1.
